sr_cmd_arbiter: RTL

SR_CMD_ARBITER -- requirements
Module: sr_cmd_arbiter

---
 rtl/sr_cmd_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sr_cmd_arbiter.sv
// sr_cmd_arbiter: two requesters share one command slot that updates a bank
// of JK-style state bits. Ties go to a round-robin pointer; every accepted
// command spends one cycle in EXEC and retires with a one-cycle done pulse.
module sr_cmd_arbiter #(
  parameter int IW = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  input  logic [1:0]           a_op,
  input  logic [IW-1:0]        a_idx,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [1:0]           b_op,
  input  logic [IW-1:0]        b_idx,
  output logic                 b_ready,
  output logic [(2**IW)-1:0]   q,
  output logic                 done,
  output logic                 done_src,
  output logic                 busy,
  output logic [7:0]           cmd_cnt
);

  localparam int N = 2**IW;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic [1:0]      op_q, op_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            src_q, src_d;
  logic [N-1:0]    q_q, q_d;
  logic            done_q, done_d;
  logic            done_src_q, done_src_d;
  logic [7:0]      cnt_q, cnt_d;

  logic            a_rdy, b_rdy;

  // Grant: only in IDLE; a lone requester wins, a tie goes to the pointer.
  always_comb begin
    a_rdy = 1'b0;
    b_rdy = 1'b0;
    if (state_q == IDLE) begin
      if (a_valid && b_valid) begin
        a_rdy = ~ptr_q;
        b_rdy = ptr_q;
      end else begin
        a_rdy = a_valid;
        b_rdy = b_valid;
      end
    end
  end

  // Next state: capture the winner in IDLE, apply it and retire it in EXEC.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    op_d       = op_q;
    idx_d      = idx_q;
    src_d      = src_q;
    q_d        = q_q;
    done_d     = 1'b0;
    done_src_d = done_src_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (a_rdy || b_rdy) begin
          src_d   = b_rdy;
          op_d    = b_rdy ? b_op  : a_op;
          idx_d   = b_rdy ? b_idx : a_idx;
          ptr_d   = a_rdy;
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (op_q)
          2'b01:   q_d[idx_q] = 1'b0;
          2'b10:   q_d[idx_q] = 1'b1;
          2'b11:   q_d[idx_q] = ~q_q[idx_q];
          default: q_d[idx_q] = q_q[idx_q];
        endcase
        done_d     = 1'b1;
        done_src_d = src_q;
        cnt_d      = cnt_q + 8'd1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any captured command without retiring it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      op_q       <= 2'b00;
      idx_q      <= '0;
      src_q      <= 1'b0;
      q_q        <= '0;
      done_q     <= 1'b0;
      done_src_q <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      src_q      <= src_d;
      q_q        <= q_d;
      done_q     <= done_d;
      done_src_q <= done_src_d;
      cnt_q      <= cnt_d;
    end
  end

  assign a_ready  = a_rdy;
  assign b_ready  = b_rdy;
  assign q        = q_q;
  assign done     = done_q;
  assign done_src = done_src_q;
  assign busy     = (state_q == EXEC);
  assign cmd_cnt  = cnt_q;

endmodule
